mcu_spi: RTL and testbench

- SPI slave bridge between the board MCU and the FPGA-side control targets: system control, HID, OSD and SD card.
- Deserialises MOSI bytes in the `clk` domain.
- Uses the first byte of each transaction to select a target.
- Delivers the following bytes as the target's strobe/start/data byte stream.
- Serialises the selected target's response byte onto MISO.
- Sits directly upstream of the system-control block and drives its `data_in_strobe`, `data_in_start` and `data_in`.

---
 rtl/mcu_spi_if.sv | 26 ++
 rtl/mcu_spi.sv | 179 +++++++++++++++++
 tb/tb_mcu_spi.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mcu_spi_if.sv
// Byte-stream bus between the MCU SPI bridge and its four control targets.
`timescale 1ns/1ps
interface mcu_spi_if;
    logic       mcu_sys_strobe;
    logic       mcu_hid_strobe;
    logic       mcu_osd_strobe;
    logic       mcu_sdc_strobe;
    logic       mcu_start;
    logic [7:0] mcu_dout;
    logic [7:0] mcu_sys_din;
    logic [7:0] mcu_hid_din;
    logic [7:0] mcu_osd_din;
    logic [7:0] mcu_sdc_din;

    modport master (
        output mcu_sys_strobe, mcu_hid_strobe, mcu_osd_strobe, mcu_sdc_strobe,
        output mcu_start, mcu_dout,
        input  mcu_sys_din, mcu_hid_din, mcu_osd_din, mcu_sdc_din
    );

    modport slave (
        input  mcu_sys_strobe, mcu_hid_strobe, mcu_osd_strobe, mcu_sdc_strobe,
        input  mcu_start, mcu_dout,
        output mcu_sys_din, mcu_hid_din, mcu_osd_din, mcu_sdc_din
    );
endinterface

// File: rtl/mcu_spi.sv
// SPI mode-0 slave oversampled in clk: first byte selects a target, following
// bytes are strobed to it, and the target's response byte is shifted out on MISO.
`timescale 1ns/1ps
module mcu_spi #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_io_ss,
    input  logic       spi_io_clk,
    input  logic       spi_io_din,
    output logic       spi_io_dout,
    mcu_spi_if.master  bus
);

    localparam int unsigned SETTLE = SYNC_STAGES + 1;
    localparam int unsigned SET_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TARGET,
        ST_CMD,
        ST_DATA
    } state_e;

    typedef enum logic [2:0] {
        TGT_SYS  = 3'd0,
        TGT_HID  = 3'd1,
        TGT_OSD  = 3'd2,
        TGT_SDC  = 3'd3,
        TGT_NONE = 3'd4
    } tgt_e;

    logic [SYNC_STAGES-1:0] ss_sync_q, sclk_sync_q, din_sync_q;
    logic                   ss_dly_q, sclk_dly_q;
    logic                   ss_s, sclk_s, din_s;
    logic                   ss_fall, sclk_rise, sclk_fall;

    state_e     state_q, state_d;
    tgt_e       tgt_q, tgt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    logic [3:0] strobe_q, strobe_d;
    logic       start_q, start_d;
    logic [7:0] data_q, data_d;
    logic       dout_q, dout_d;
    logic       resync_q, resync_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic       settle_done;
    logic       byte_done;
    logic [7:0] resp;

    // Input synchronisers plus one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            ss_sync_q   <= '1;
            sclk_sync_q <= '0;
            din_sync_q  <= '0;
            ss_dly_q    <= 1'b1;
            sclk_dly_q  <= 1'b0;
        end else begin
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi_io_ss};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_io_clk};
            din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], spi_io_din};
            ss_dly_q    <= ss_sync_q[SYNC_STAGES-1];
            sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
        end
    end

    assign ss_s        = ss_sync_q[SYNC_STAGES-1];
    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign din_s       = din_sync_q[SYNC_STAGES-1];
    assign ss_fall     = ss_dly_q & ~ss_s;
    assign sclk_rise   = ~sclk_dly_q & sclk_s;
    assign sclk_fall   = sclk_dly_q & ~sclk_s;
    assign settle_done = (settle_q == SET_W'(SETTLE));

    always_comb begin
        case (tgt_q)
            TGT_SYS: resp = bus.mcu_sys_din;
            TGT_HID: resp = bus.mcu_hid_din;
            TGT_OSD: resp = bus.mcu_osd_din;
            TGT_SDC: resp = bus.mcu_sdc_din;
            default: resp = 8'h00;
        endcase
        if (state_q == ST_TARGET) resp = 8'h00;
    end

    // Next-state and output logic
    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        strobe_d  = '0;
        start_d   = start_q;
        data_d    = data_q;
        resync_d  = resync_q;
        settle_d  = settle_q;
        byte_done = 1'b0;

        if (!settle_done) settle_d = SET_W'(settle_q + SET_W'(1));
        // The reset values of the ss chain are not a real ss-high observation
        if (settle_done && ss_s && ss_dly_q) resync_d = 1'b0;

        if (ss_s || resync_q) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            tx_d      = 8'h00;
        end else if (state_q == ST_IDLE) begin
            bit_cnt_d = 3'd0;
            tx_d      = 8'h00;
            if (ss_fall) state_d = ST_TARGET;
        end else begin
            if (sclk_rise) begin
                rx_d      = {rx_q[6:0], din_s};
                bit_cnt_d = 3'(bit_cnt_q + 3'd1);
                byte_done = (bit_cnt_q == 3'd7);
            end
            if (sclk_fall) begin
                tx_d = (bit_cnt_q == 3'd0) ? resp : {tx_q[6:0], 1'b0};
            end
            if (byte_done) begin
                if (state_q == ST_TARGET) begin
                    tgt_d   = (rx_d[7:2] == 6'd0) ? tgt_e'({1'b0, rx_d[1:0]}) : TGT_NONE;
                    state_d = ST_CMD;
                end else begin
                    if (tgt_q != TGT_NONE) begin
                        strobe_d[tgt_q[1:0]] = 1'b1;
                        start_d              = (state_q == ST_CMD);
                        data_d               = rx_d;
                    end
                    state_d = ST_DATA;
                end
            end
        end

        dout_d = ss_s ? 1'b0 : tx_d[7];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            tgt_q     <= TGT_NONE;
            bit_cnt_q <= 3'd0;
            rx_q      <= 8'h00;
            tx_q      <= 8'h00;
            strobe_q  <= 4'd0;
            start_q   <= 1'b0;
            data_q    <= 8'h00;
            dout_q    <= 1'b0;
            resync_q  <= 1'b1;
            settle_q  <= '0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            strobe_q  <= strobe_d;
            start_q   <= start_d;
            data_q    <= data_d;
            dout_q    <= dout_d;
            resync_q  <= resync_d;
            settle_q  <= settle_d;
        end
    end

    assign spi_io_dout        = dout_q;
    assign bus.mcu_sys_strobe = strobe_q[0];
    assign bus.mcu_hid_strobe = strobe_q[1];
    assign bus.mcu_osd_strobe = strobe_q[2];
    assign bus.mcu_sdc_strobe = strobe_q[3];
    assign bus.mcu_start      = start_q;
    assign bus.mcu_dout       = data_q;

endmodule

// File: tb/tb_mcu_spi.sv
// Directed bench for mcu_spi: target select, strobes, MISO responses, abort and reset recovery.
`timescale 1ns/1ps
module tb_mcu_spi;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ss = 1'b1;
    logic sclk = 1'b0;
    logic mosi = 1'b0;
    logic miso;

    mcu_spi_if bus();

    mcu_spi #(.SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .spi_io_ss   (ss),
        .spi_io_clk  (sclk),
        .spi_io_din  (mosi),
        .spi_io_dout (miso),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    longint cyc = 0;

    logic [3:0] ev_sel[$];
    logic       ev_start[$];
    logic [7:0] ev_data[$];
    longint     ev_cyc[$];
    logic [7:0] txq[$];
    logic [7:0] rxq[$];

    // Record every cycle in which any strobe is high
    always @(negedge clk) begin
        logic [3:0] s;
        cyc++;
        s = {bus.mcu_sdc_strobe, bus.mcu_osd_strobe, bus.mcu_hid_strobe, bus.mcu_sys_strobe};
        if (s != 4'd0) begin
            ev_sel.push_back(s);
            ev_start.push_back(bus.mcu_start);
            ev_data.push_back(bus.mcu_dout);
            ev_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] b, input int nbits, output logic [7:0] r);
        r = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = b[7-i];
            #40 sclk = 1'b1;
            r = {r[6:0], miso};
            #40 sclk = 1'b0;
        end
    endtask

    task automatic ss_lo();
        @(negedge clk);
        #2 ss = 1'b0;
        #80;
    endtask

    task automatic ss_hi();
        #40 ss = 1'b1;
        #200;
    endtask

    task automatic clear_ev();
        ev_sel.delete();
        ev_start.delete();
        ev_data.delete();
        ev_cyc.delete();
        rxq.delete();
    endtask

    task automatic run_txn();
        logic [7:0] r;
        clear_ev();
        ss_lo();
        foreach (txq[i]) begin
            xfer(txq[i], 8, r);
            rxq.push_back(r);
        end
        ss_hi();
    endtask

    task automatic chk_ev(input string tag, input int idx, input logic [3:0] sel,
                          input logic start, input logic [7:0] data);
        if (idx < ev_sel.size()) begin
            chk({tag, "_sel"},   32'(ev_sel[idx]),   32'(sel));
            chk({tag, "_start"}, 32'(ev_start[idx]), 32'(start));
            chk({tag, "_data"},  32'(ev_data[idx]),  32'(data));
        end
    endtask

    initial begin
        logic [7:0] r;
        logic [7:0] d6[16];

        bus.mcu_sys_din = 8'h5C;
        bus.mcu_hid_din = 8'h33;
        bus.mcu_osd_din = 8'h77;
        bus.mcu_sdc_din = 8'h99;

        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst_strobes", 32'({bus.mcu_sdc_strobe, bus.mcu_osd_strobe,
                                bus.mcu_hid_strobe, bus.mcu_sys_strobe}), 32'h0);
        chk("rst_start", 32'(bus.mcu_start), 32'h0);
        chk("rst_dout",  32'(bus.mcu_dout),  32'h0);
        chk("rst_miso",  32'(miso),          32'h0);

        // Sys target: command then two data bytes
        txq = '{8'h00, 8'h04, 8'h52, 8'h00};
        run_txn();
        chk("t1_count", 32'(ev_sel.size()), 32'd3);
        chk_ev("t1_e0", 0, 4'b0001, 1'b1, 8'h04);
        chk_ev("t1_e1", 1, 4'b0001, 1'b0, 8'h52);
        chk_ev("t1_e2", 2, 4'b0001, 1'b0, 8'h00);

        // MISO returns the previous byte's response
        txq = '{8'h00, 8'h00, 8'hAA, 8'hAA};
        run_txn();
        chk("t2_rx0", 32'(rxq[0]), 32'h00);
        chk("t2_rx1", 32'(rxq[1]), 32'h5C);
        chk("t2_rx2", 32'(rxq[2]), 32'h5C);
        chk("t2_rx3", 32'(rxq[3]), 32'h5C);

        txq = '{8'h01, 8'h00, 8'h00};
        run_txn();
        chk("t2h_rx0", 32'(rxq[0]), 32'h00);
        chk("t2h_rx1", 32'(rxq[1]), 32'h33);
        chk("t2h_rx2", 32'(rxq[2]), 32'h33);
        chk("t2h_count", 32'(ev_sel.size()), 32'd2);
        chk_ev("t2h_e0", 0, 4'b0010, 1'b1, 8'h00);

        // Invalid target: nothing strobed, MISO zero
        txq = '{8'h07, 8'h01, 8'h02};
        run_txn();
        chk("t3_count", 32'(ev_sel.size()), 32'd0);
        chk("t3_rx0", 32'(rxq[0]), 32'h00);
        chk("t3_rx1", 32'(rxq[1]), 32'h00);
        chk("t3_rx2", 32'(rxq[2]), 32'h00);

        // Abort mid-byte, then a fresh transaction
        clear_ev();
        ss_lo();
        xfer(8'h03, 8, r);
        xfer(8'h10, 8, r);
        xfer(8'hFF, 5, r);
        ss_hi();
        chk("t4a_count", 32'(ev_sel.size()), 32'd1);
        chk_ev("t4a_e0", 0, 4'b1000, 1'b1, 8'h10);
        txq = '{8'h02, 8'h08};
        run_txn();
        chk("t4b_count", 32'(ev_sel.size()), 32'd1);
        chk_ev("t4b_e0", 0, 4'b0100, 1'b1, 8'h08);

        // Reset mid-command with ss held low
        clear_ev();
        ss_lo();
        xfer(8'h00, 8, r);
        xfer(8'hA5, 3, r);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("t5_strobes", 32'({bus.mcu_sdc_strobe, bus.mcu_osd_strobe,
                               bus.mcu_hid_strobe, bus.mcu_sys_strobe}), 32'h0);
        chk("t5_start", 32'(bus.mcu_start), 32'h0);
        chk("t5_dout",  32'(bus.mcu_dout),  32'h0);
        chk("t5_miso",  32'(miso),          32'h0);
        #2;
        xfer(8'h28, 5, r);
        xfer(8'h55, 8, r);
        xfer(8'h66, 8, r);
        ss_hi();
        chk("t5_count", 32'(ev_sel.size()), 32'd0);
        txq = '{8'h00, 8'h05};
        run_txn();
        chk("t5b_count", 32'(ev_sel.size()), 32'd1);
        chk_ev("t5b_e0", 0, 4'b0001, 1'b1, 8'h05);

        // Continuous stream at f_clk = 8 x f_sclk
        txq = '{8'h00, 8'h80};
        for (int i = 0; i < 16; i++) begin
            d6[i] = 8'(i * 31 + 3);
            txq.push_back(d6[i]);
        end
        run_txn();
        chk("t6_count", 32'(ev_sel.size()), 32'd17);
        chk_ev("t6_cmd", 0, 4'b0001, 1'b1, 8'h80);
        for (int i = 0; i < 16; i++) begin
            chk_ev($sformatf("t6_d%0d", i), i + 1, 4'b0001, 1'b0, d6[i]);
            if (i + 1 < ev_cyc.size())
                chk($sformatf("t6_gap%0d", i), 32'(ev_cyc[i+1] - ev_cyc[i]), 32'd64);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
